// File: rtl/mult_div_accel.sv
// mult_div_accel
//   Multi-cycle multiply/divide peripheral on the 6502 data bus.
//   The CPU writes two unsigned WIDTH-bit operands byte by byte and then a
//   control byte. The block runs a shift-add multiply or a restoring divide
//   at one bit per cycle and posts a 2*WIDTH-bit result.
//
//   Register map (NB = WIDTH/8, bytes little-endian):
//     0    .. NB-1    OPA
//     NB   .. 2NB-1   OPB
//     2NB  .. 4NB-1   RESULT (mul: product; div: {remainder, quotient})
//     4NB             CTRL on write (b0 START, b1 MODE, b2 IE, b3 ACK)
//                     STAT on read  (b7 BUSY, b6 DONE, b5 DIV0, b2 IE, b1 MODE)
//     above 4NB       read 0x00, writes ignored
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     D     bidirectional data bus, driven only while CE=1 and RWB=1
//     RWB   1 = CPU read, 0 = CPU write
//     CE    chip enable from the address decoder
//     A     register offset
//     IRQB  active-low interrupt, low while DONE and IE are both set
module mult_div_accel #(
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(4 * (WIDTH / 8) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [7:0]    D,
  input  logic          RWB,
  input  logic          CE,
  input  logic [AW-1:0] A,
  output logic          IRQB
);

  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [AW-1:0] A_CTRL = AW'(4 * NB);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   opa, opb;
  // Working operand: multiplicand in mul mode, divisor in div mode.
  logic [WIDTH-1:0]   wop;
  // Mul: {partial product, remaining multiplier bits}.
  // Div: {remainder, quotient / remaining dividend bits}.
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [2*WIDTH-1:0] result;
  logic [CW-1:0]      cnt;
  logic               mode, ie, done, div0;
  logic               wmode, wdz;
  logic               busy, wr, ctrl_wr;
  logic [7:0]         rd_data;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;

  assign busy    = (state != IDLE);
  assign wr      = CE && !RWB;
  assign ctrl_wr = wr && (A == A_CTRL);
  assign IRQB    = !(done && ie);
  assign D       = (CE && RWB) ? rd_data : 8'hzz;

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, wop} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, wop};
    if (wmode) begin
      // The remainder stays below 2*divisor, so the top bit of the
      // difference is a clean borrow flag.
      if (div_diff[WIDTH])
        acc_nx = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ctrl_wr && D[0])
          state_n = (D[1] && (opb == '0)) ? FINISH : RUN;
      end
      RUN: begin
        if (cnt == CW'(1))
          state_n = FINISH;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      wop    <= '0;
      acc    <= '0;
      result <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      ie     <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      wmode  <= 1'b0;
      wdz    <= 1'b0;
    end else begin
      state <= state_n;

      if (wr && !busy) begin
        for (int i = 0; i < NB; i++) begin
          if (A == AW'(i))      opa[8*i +: 8] <= D;
          if (A == AW'(NB + i)) opb[8*i +: 8] <= D;
        end
      end

      if (ctrl_wr) begin
        ie <= D[2];
        if (!busy) begin
          mode <= D[1];
          if (D[3]) begin
            done <= 1'b0;
            div0 <= 1'b0;
          end
          if (D[0]) begin
            done  <= 1'b0;
            div0  <= 1'b0;
            wmode <= D[1];
            wdz   <= D[1] && (opb == '0);
            wop   <= D[1] ? opb : opa;
            acc   <= {{WIDTH{1'b0}}, (D[1] ? opa : opb)};
            cnt   <= CW'(WIDTH);
          end
        end
      end

      case (state)
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          // Divide by zero: quotient all ones, remainder is the dividend,
          // which still sits untouched in the low half of acc.
          if (wdz) begin
            result <= {acc[WIDTH-1:0], {WIDTH{1'b1}}};
            div0   <= 1'b1;
          end else begin
            result <= acc;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (A == AW'(i))      rd_data = opa[8*i +: 8];
      if (A == AW'(NB + i)) rd_data = opb[8*i +: 8];
    end
    for (int i = 0; i < 2*NB; i++) begin
      if (A == AW'(2*NB + i)) rd_data = result[8*i +: 8];
    end
    if (A == A_CTRL)
      rd_data = {busy, done, div0, 2'b00, ie, mode, 1'b0};
  end

endmodule

// File: tb/tb_mult_div_accel.sv
module tb_mult_div_accel;

  localparam int W  = 16;
  localparam int NB = W / 8;
  localparam int AW = $clog2(4 * NB + 1);
  localparam logic [AW-1:0] CTRL = AW'(4 * NB);

  logic          clk = 1'b0;
  logic          rst;
  logic          RWB;
  logic          CE;
  logic [AW-1:0] A;
  logic [7:0]    d_drv;
  logic          d_oe;
  wire  [7:0]    D;
  logic          IRQB;

  int errors = 0;
  int checks = 0;

  assign D = d_oe ? d_drv : 8'hzz;

  mult_div_accel #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .D    (D),
    .RWB  (RWB),
    .CE   (CE),
    .A    (A),
    .IRQB (IRQB)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [7:0] data);
    @(negedge clk);
    CE = 1'b1; RWB = 1'b0; A = addr; d_drv = data; d_oe = 1'b1;
    @(posedge clk);
    #1;
    CE = 1'b0; RWB = 1'b1; d_oe = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, output logic [7:0] data);
    @(negedge clk);
    CE = 1'b1; RWB = 1'b1; A = addr; d_oe = 1'b0;
    #1;
    data = D;
    CE = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < NB; i++) begin
      wr(AW'(i), a[8*i +: 8]);
      wr(AW'(NB + i), b[8*i +: 8]);
    end
  endtask

  task automatic rd_result(output logic [2*W-1:0] r);
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < 2*NB; i++) begin
      rd(AW'(2*NB + i), b);
      r[8*i +: 8] = b;
    end
  endtask

  task automatic rd_opa(output logic [W-1:0] r);
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      rd(AW'(i), b);
      r[8*i +: 8] = b;
    end
  endtask

  // Counts clock edges until BUSY drops, bounded.
  task automatic wait_idle(output int n);
    logic [7:0] s;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      rd(CTRL, s);
    end while (s[7] === 1'b1 && n < 200);
  endtask

  task automatic start_and_wait(input logic [7:0] ctrl, output int n);
    logic [7:0] s;
    wr(CTRL, ctrl);
    rd(CTRL, s);
    chk("busy_after_start", 64'(s[7]), 64'(1));
    wait_idle(n);
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic div);
    logic [2*W-1:0] aa, bb;
    aa = {{W{1'b0}}, a};
    bb = {{W{1'b0}}, b};
    if (!div)     return aa * bb;
    if (b == '0)  return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  logic [7:0]     s;
  logic [2*W-1:0] r;
  logic [W-1:0]   ra, ta, tb;
  logic           tm;
  int             n;

  initial begin
    rst = 1'b1; CE = 1'b0; RWB = 1'b1; A = '0; d_drv = 8'h00; d_oe = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: every offset reads zero, IRQB high.
    for (int i = 0; i < (1 << AW); i++) begin
      rd(AW'(i), s);
      chk($sformatf("reset_off%0d", i), 64'(s), 64'(0));
    end
    chk("reset_irqb", 64'(IRQB), 64'(1));

    // Directed multiply.
    load(16'h1234, 16'h5678);
    start_and_wait(8'h01, n);
    chk("mul1_cycles", 64'(n), 64'(W + 1));
    rd_result(r);
    chk("mul1_result", 64'(r), 64'(32'h0626_0060));
    rd(CTRL, s);
    chk("mul1_stat", 64'(s), 64'(8'h40));

    // Bus released while not selected: bench drives 0x00 and must see it.
    @(negedge clk);
    CE = 1'b0; RWB = 1'b1; A = CTRL; d_drv = 8'h00; d_oe = 1'b1;
    #1 chk("bus_released", 64'(D), 64'(0));
    d_oe = 1'b0;

    // Offsets above the map ignore writes.
    wr(AW'(4*NB + 1), 8'hFF);
    rd(AW'(4*NB + 1), s);
    chk("unmapped_read", 64'(s), 64'(0));

    load(16'hFFFF, 16'hFFFF);
    start_and_wait(8'h01, n);
    rd_result(r);
    chk("mul_max_result", 64'(r), 64'(32'hFFFE_0001));

    load(16'h03E8, 16'h0007);
    start_and_wait(8'h03, n);
    chk("div_cycles", 64'(n), 64'(W + 1));
    rd_result(r);
    chk("div_result", 64'(r), 64'(32'h0006_008E));
    rd(CTRL, s);
    chk("div_stat", 64'(s), 64'(8'h42));

    // Divide by zero completes on the edge after START.
    load(16'hABCD, 16'h0000);
    start_and_wait(8'h03, n);
    chk("div0_cycles", 64'(n), 64'(1));
    rd_result(r);
    chk("div0_result", 64'(r), 64'(32'hABCD_FFFF));
    rd(CTRL, s);
    chk("div0_stat", 64'(s), 64'(8'h62));
    wr(CTRL, 8'h0A);
    rd(CTRL, s);
    chk("div0_ack_stat", 64'(s), 64'(8'h02));

    // Interrupt flow with writes attempted while busy.
    load(16'h1357, 16'h2468);
    wr(CTRL, 8'h05);
    chk("ie_irqb_busy", 64'(IRQB), 64'(1));
    wr(AW'(0), 8'h00);
    wr(AW'(1), 8'h00);
    wr(CTRL, 8'h05);
    wait_idle(n);
    chk("ie_cycles_left", 64'(n), 64'(W + 1 - 3));
    rd_result(r);
    chk("ie_result", 64'(r), 64'(model(16'h1357, 16'h2468, 1'b0)));
    rd_opa(ra);
    chk("ie_opa_kept", 64'(ra), 64'(16'h1357));
    rd(CTRL, s);
    chk("ie_stat", 64'(s), 64'(8'h44));
    chk("ie_irqb_low", 64'(IRQB), 64'(0));
    wr(CTRL, 8'h0C);
    rd(CTRL, s);
    chk("ack_stat", 64'(s), 64'(8'h04));
    chk("ack_irqb_high", 64'(IRQB), 64'(1));

    // Reset in the middle of RUN.
    load(16'h00FF, 16'h0101);
    wr(CTRL, 8'h05);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rd(CTRL, s);
    chk("rst_mid_stat", 64'(s), 64'(0));
    rd_result(r);
    chk("rst_mid_result", 64'(r), 64'(0));
    chk("rst_mid_irqb", 64'(IRQB), 64'(1));
    rd_opa(ra);
    chk("rst_mid_opa", 64'(ra), 64'(0));

    load(16'h00FF, 16'h0101);
    start_and_wait(8'h01, n);
    chk("post_rst_cycles", 64'(n), 64'(W + 1));
    rd_result(r);
    chk("post_rst_result", 64'(r), 64'(32'h0000_FFFF));

    // Randomized operations against the arithmetic model.
    for (int k = 0; k < 12; k++) begin
      ta = W'($urandom);
      case ($urandom_range(0, 4))
        0:       tb = '0;
        1:       tb = W'($urandom_range(1, 15));
        default: tb = W'($urandom);
      endcase
      tm = 1'($urandom_range(0, 1));
      load(ta, tb);
      start_and_wait({6'b0, tm, 1'b1}, n);
      chk($sformatf("rnd%0d_cycles", k), 64'(n),
          64'((tm && tb == '0) ? 1 : W + 1));
      rd_result(r);
      chk($sformatf("rnd%0d_result", k), 64'(r), 64'(model(ta, tb, tm)));
      rd(CTRL, s);
      chk($sformatf("rnd%0d_stat", k), 64'(s),
          64'({1'b0, 1'b1, (tm && tb == '0), 2'b00, 1'b0, tm, 1'b0}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
